// File: rtl/vop2_pkg.sv
// rtl/vop2_pkg.sv - VOP2 opcode, source-operand codes, issued bundle type
// Shared by vop2_field_split and vop2_issue_decoder (VOP2_ILLEGAL_OP_EN selects op checking).
package vop2_pkg;

  localparam logic [5:0] V_CNDMASK_B32     = 6'd1;
  localparam logic [5:0] V_READLANE_B32    = 6'd2;
  localparam logic [5:0] V_ADD_F32         = 6'd3;
  localparam logic [5:0] V_SUB_F32         = 6'd4;
  localparam logic [5:0] V_SUBREV_F32      = 6'd5;
  localparam logic [5:0] V_MUL_F32         = 6'd7;
  localparam logic [5:0] V_MUL_I32_I24     = 6'd8;
  localparam logic [5:0] V_MUL_HI_I32_I24  = 6'd9;
  localparam logic [5:0] V_MUL_U32_U24     = 6'd10;
  localparam logic [5:0] V_MUL_HI_U32_U24  = 6'd11;
  localparam logic [5:0] V_MIN_F32         = 6'd12;
  localparam logic [5:0] V_MAX_F32         = 6'd13;
  localparam logic [5:0] V_LSHRREV_B32     = 6'd15;
  localparam logic [5:0] V_ASHRREV_I32     = 6'd16;
  localparam logic [5:0] V_MIN_I32         = 6'd17;
  localparam logic [5:0] V_MAX_I32         = 6'd18;
  localparam logic [5:0] V_MIN_U32         = 6'd19;

  localparam logic [8:0] LIT_SRC   = 9'd255;
  localparam logic [8:0] DPP16_SRC = 9'd250;
  localparam logic [8:0] DPP8_SRC  = 9'd233;
  localparam logic [8:0] SDWA_SRC  = 9'd249;

  typedef struct packed {
    logic [5:0]  op;
    logic [7:0]  vdst;
    logic [7:0]  vsrc1;
    logic [8:0]  src0;
    logic        has_lit;
    logic [31:0] literal;
  } vop2_bundle_t;

  function automatic logic is_supported_op(input logic [5:0] op);
    case (op)
      V_CNDMASK_B32, V_READLANE_B32, V_ADD_F32, V_SUB_F32, V_SUBREV_F32,
      V_MUL_F32, V_MUL_I32_I24, V_MUL_HI_I32_I24, V_MUL_U32_U24,
      V_MUL_HI_U32_U24, V_MIN_F32, V_MAX_F32, V_LSHRREV_B32,
      V_ASHRREV_I32, V_MIN_I32, V_MAX_I32, V_MIN_U32: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/vop2_field_split.sv
// rtl/vop2_field_split.sv - combinational VOP2 dword field split and classification
// bad_op is only driven when VOP2_ILLEGAL_OP_EN is defined; otherwise it is tied low.
module vop2_field_split
  import vop2_pkg::*;
(
  input  logic [31:0] dword,
  output logic [5:0]  op,
  output logic [7:0]  vdst,
  output logic [7:0]  vsrc1,
  output logic [8:0]  src0,
  output logic        is_vop2,
  output logic        needs_lit,
  output logic        bad_src,
  output logic        bad_op
);

  assign op        = dword[30:25];
  assign vdst      = dword[24:17];
  assign vsrc1     = dword[16:9];
  assign src0      = dword[8:0];
  assign is_vop2   = ~dword[31];
  assign needs_lit = (src0 == LIT_SRC);
  assign bad_src   = (src0 == DPP16_SRC) || (src0 == DPP8_SRC) || (src0 == SDWA_SRC);

`ifdef VOP2_ILLEGAL_OP_EN
  assign bad_op = ~is_supported_op(op);
`else
  assign bad_op = 1'b0;
`endif

endmodule

// File: rtl/vop2_issue_decoder.sv
// rtl/vop2_issue_decoder.sv - VOP2 instruction stream decoder issuing bundles to the ALU
// Optional opcode legality check under VOP2_ILLEGAL_OP_EN (see vop2_field_split).
module vop2_issue_decoder
  import vop2_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_dword,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_op,
  output logic [7:0]       out_vdst,
  output logic [7:0]       out_vsrc1,
  output logic [8:0]       out_src0,
  output logic             out_has_lit,
  output logic [31:0]      out_literal,
  output logic             err,
  output logic [CNT_W-1:0] issued_cnt
);

  typedef enum logic [1:0] {
    S_INST = 2'd0,
    S_LIT  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t       state;
  vop2_bundle_t bundle;
  vop2_bundle_t dec;
  logic         lit_drop;

  logic [5:0] f_op;
  logic [7:0] f_vdst;
  logic [7:0] f_vsrc1;
  logic [8:0] f_src0;
  logic       f_is_vop2;
  logic       f_needs_lit;
  logic       f_bad_src;
  logic       f_bad_op;
  logic       in_acc;
  logic       drop_word;

  vop2_field_split u_split (
    .dword     (in_dword),
    .op        (f_op),
    .vdst      (f_vdst),
    .vsrc1     (f_vsrc1),
    .src0      (f_src0),
    .is_vop2   (f_is_vop2),
    .needs_lit (f_needs_lit),
    .bad_src   (f_bad_src),
    .bad_op    (f_bad_op)
  );

  // In S_OUT a new word can only enter when the held bundle leaves in the same cycle.
  assign in_ready  = (state != S_OUT) || out_ready;
  assign in_acc    = in_valid && in_ready;
  assign drop_word = !f_is_vop2 || f_bad_src || (f_bad_op && !f_needs_lit);

  assign dec = '{op: f_op, vdst: f_vdst, vsrc1: f_vsrc1, src0: f_src0,
                 has_lit: 1'b0, literal: 32'd0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INST;
      out_valid  <= 1'b0;
      bundle     <= '0;
      err        <= 1'b0;
      lit_drop   <= 1'b0;
      issued_cnt <= '0;
    end else begin
      if (out_valid && out_ready)
        issued_cnt <= issued_cnt + CNT_W'(1);

      case (state)
        S_INST, S_OUT: begin
          if (in_acc) begin
            if (drop_word) begin
              err       <= 1'b1;
              out_valid <= 1'b0;
              state     <= S_INST;
            end else if (f_needs_lit) begin
              // An illegal op still owns its literal dword; swallow it in S_LIT.
              bundle    <= dec;
              lit_drop  <= f_bad_op;
              if (f_bad_op)
                err <= 1'b1;
              out_valid <= 1'b0;
              state     <= S_LIT;
            end else begin
              bundle    <= dec;
              out_valid <= 1'b1;
              state     <= S_OUT;
            end
          end else if (state == S_OUT && out_ready) begin
            out_valid <= 1'b0;
            state     <= S_INST;
          end
        end
        S_LIT: begin
          if (in_valid) begin
            if (lit_drop) begin
              lit_drop <= 1'b0;
              state    <= S_INST;
            end else begin
              bundle.literal <= in_dword;
              bundle.has_lit <= 1'b1;
              out_valid      <= 1'b1;
              state          <= S_OUT;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= S_INST;
        end
      endcase
    end
  end

  assign out_op      = bundle.op;
  assign out_vdst    = bundle.vdst;
  assign out_vsrc1   = bundle.vsrc1;
  assign out_src0    = bundle.src0;
  assign out_has_lit = bundle.has_lit;
  assign out_literal = bundle.literal;

endmodule

// File: tb/tb_vop2_issue_decoder.sv
// tb/tb_vop2_issue_decoder.sv - directed self-checking bench for vop2_issue_decoder
// Counter built narrow (CNT_W=4) so the wrap can be reached; honours VOP2_ILLEGAL_OP_EN.
module tb_vop2_issue_decoder;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_dword;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       out_op;
  logic [7:0]       out_vdst;
  logic [7:0]       out_vsrc1;
  logic [8:0]       out_src0;
  logic             out_has_lit;
  logic [31:0]      out_literal;
  logic             err;
  logic [CNT_W-1:0] issued_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vop2_issue_decoder #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dword    (in_dword),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_vdst    (out_vdst),
    .out_vsrc1   (out_vsrc1),
    .out_src0    (out_src0),
    .out_has_lit (out_has_lit),
    .out_literal (out_literal),
    .err         (err),
    .issued_cnt  (issued_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_dword = 32'd0; out_ready = 1'b0;
    step(); step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_cnt", {28'd0, issued_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_op", {26'd0, out_op}, 32'd0);
    chk("rst_literal", out_literal, 32'd0);
    rst = 1'b0;

    // single non-literal word: op=3 vdst=0 vsrc1=5 src0=1
    in_valid = 1'b1; in_dword = 32'h0600_0A01; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("c1_valid", {31'd0, out_valid}, 32'd1);
    chk("c1_op", {26'd0, out_op}, 32'd3);
    chk("c1_vdst", {24'd0, out_vdst}, 32'd0);
    chk("c1_vsrc1", {24'd0, out_vsrc1}, 32'd5);
    chk("c1_src0", {23'd0, out_src0}, 32'd1);
    chk("c1_has_lit", {31'd0, out_has_lit}, 32'd0);
    step();
    chk("c1_cnt", {28'd0, issued_cnt}, 32'd1);
    chk("c1_idle", {31'd0, out_valid}, 32'd0);

    // literal instruction
    in_valid = 1'b1; in_dword = 32'h0600_0AFF;
    step();
    chk("c2_no_valid_mid", {31'd0, out_valid}, 32'd0);
    chk("c2_in_ready_lit", {31'd0, in_ready}, 32'd1);
    in_dword = 32'h3F80_0000;
    step();
    in_valid = 1'b0;
    chk("c2_valid", {31'd0, out_valid}, 32'd1);
    chk("c2_src0", {23'd0, out_src0}, 32'd255);
    chk("c2_has_lit", {31'd0, out_has_lit}, 32'd1);
    chk("c2_literal", out_literal, 32'h3F80_0000);
    step();
    chk("c2_cnt", {28'd0, issued_cnt}, 32'd2);
    chk("c2_idle", {31'd0, out_valid}, 32'd0);

    // backpressure then back-to-back issue
    out_ready = 1'b0; in_valid = 1'b1; in_dword = 32'h0600_0A01;
    step();
    in_dword = 32'h0800_0C02;
    for (int i = 0; i < 5; i++) begin
      chk("c3_in_ready_stall", {31'd0, in_ready}, 32'd0);
      chk("c3_valid_hold", {31'd0, out_valid}, 32'd1);
      chk("c3_op_hold", {26'd0, out_op}, 32'd3);
      chk("c3_vsrc1_hold", {24'd0, out_vsrc1}, 32'd5);
      step();
    end
    chk("c3_cnt_stall", {28'd0, issued_cnt}, 32'd2);
    out_ready = 1'b1;
    #1;
    chk("c3_in_ready_rel", {31'd0, in_ready}, 32'd1);
    step();
    chk("c3_b_valid", {31'd0, out_valid}, 32'd1);
    chk("c3_b_op", {26'd0, out_op}, 32'd4);
    chk("c3_b_vsrc1", {24'd0, out_vsrc1}, 32'd6);
    chk("c3_cnt_a", {28'd0, issued_cnt}, 32'd3);
    in_dword = 32'h0A00_0E03;
    step();
    chk("c3_c_valid", {31'd0, out_valid}, 32'd1);
    chk("c3_c_op", {26'd0, out_op}, 32'd5);
    chk("c3_c_src0", {23'd0, out_src0}, 32'd3);
    chk("c3_cnt_b", {28'd0, issued_cnt}, 32'd4);
    in_valid = 1'b0;
    step();
    chk("c3_cnt_c", {28'd0, issued_cnt}, 32'd5);
    chk("c3_idle", {31'd0, out_valid}, 32'd0);

    // bad encodings
    in_valid = 1'b1; in_dword = 32'h8000_0000;
    step();
    chk("c4_err_bit31", {31'd0, err}, 32'd1);
    chk("c4_no_bundle1", {31'd0, out_valid}, 32'd0);
    in_dword = 32'h0200_00F9;
    step();
    in_valid = 1'b0;
    chk("c4_err_sdwa", {31'd0, err}, 32'd1);
    chk("c4_no_bundle2", {31'd0, out_valid}, 32'd0);
    step();
    chk("c4_cnt", {28'd0, issued_cnt}, 32'd5);

    // op=14 handling
    in_valid = 1'b1; in_dword = 32'h1C00_0001;
    step();
    in_valid = 1'b0;
`ifdef VOP2_ILLEGAL_OP_EN
    chk("c6_op14_dropped", {31'd0, out_valid}, 32'd0);
    chk("c6_op14_err", {31'd0, err}, 32'd1);
    step();
    chk("c6_op14_cnt", {28'd0, issued_cnt}, 32'd5);
    in_valid = 1'b1; in_dword = 32'h1C00_00FF;
    step();
    in_dword = 32'h1234_5678;
    step();
    in_valid = 1'b0;
    chk("c6_lit_dropped", {31'd0, out_valid}, 32'd0);
    chk("c6_lit_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("c6_lit_cnt", {28'd0, issued_cnt}, 32'd5);
`else
    chk("c6_op14_valid", {31'd0, out_valid}, 32'd1);
    chk("c6_op14_op", {26'd0, out_op}, 32'd14);
    step();
    chk("c6_op14_cnt", {28'd0, issued_cnt}, 32'd6);
`endif

    // reset while waiting for a literal
    in_valid = 1'b1; in_dword = 32'h0600_0AFF;
    step();
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("c5a_valid", {31'd0, out_valid}, 32'd0);
    chk("c5a_err", {31'd0, err}, 32'd0);
    chk("c5a_cnt", {28'd0, issued_cnt}, 32'd0);
    chk("c5a_in_ready", {31'd0, in_ready}, 32'd1);
    // a word arriving now must be decoded as an instruction, not a literal
    in_valid = 1'b1; in_dword = 32'h0600_0A01; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("c5b_held", {31'd0, out_valid}, 32'd1);
    chk("c5b_has_lit", {31'd0, out_has_lit}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("c5b_valid", {31'd0, out_valid}, 32'd0);
    chk("c5b_cnt", {28'd0, issued_cnt}, 32'd0);
    chk("c5b_in_ready", {31'd0, in_ready}, 32'd1);
    chk("c5b_op", {26'd0, out_op}, 32'd0);

    // counter wrap: 15 back-to-back then one more
    out_ready = 1'b1; in_valid = 1'b1; in_dword = 32'h0600_0A01;
    for (int i = 0; i < 15; i++) step();
    in_valid = 1'b0;
    step();
    chk("wrap_max", {28'd0, issued_cnt}, 32'd15);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("wrap_zero", {28'd0, issued_cnt}, 32'd0);
    chk("wrap_idle", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
